ad7476a_sample_averager: RTL and testbench

//  Downstream companion of the AD7476A SPI interface. Paces conversions by pulsing

---
 rtl/ad7476a_sample_averager.sv | 89 ++++++++
 tb/tb_ad7476a_sample_averager.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad7476a_sample_averager.sv
// ad7476a_sample_averager: paces ADC conversion requests and streams the rounded mean of 2**AVG_LOG2 samples
module ad7476a_sample_averager #(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int SAMPLE_RATE_HZ = 1000000,
  parameter int AVG_LOG2       = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        clear_i,
  output logic        request_o,
  input  logic [11:0] adc_data_i,
  input  logic        adc_valid_i,
  output logic [11:0] avg_data_o,
  output logic        avg_valid_o,
  input  logic        avg_ready_i,
  output logic        late_o,
  output logic        overrun_o
);
  localparam int PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int TW     = $clog2(PERIOD < 2 ? 2 : PERIOD);
  localparam int CW     = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW     = 12 + AVG_LOG2;
  localparam int RND    = (1 << AVG_LOG2) >> 1;

  if (PERIOD < 2 || AVG_LOG2 > 8) begin : g_param_check
    $error("ad7476a_sample_averager: PERIOD must be >= 2 and AVG_LOG2 <= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, BUSY} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d, sum;
  logic [AW:0]     rounded;
  logic [11:0]     data_q, data_d;
  logic            valid_q, valid_d, late_q, late_d, ovr_q, ovr_d;
  logic            tick, take, done, load;

  always_comb begin
    tick    = timer_q == '0;
    take    = state_q == BUSY && adc_valid_i && enable_i;
    done    = take && cnt_q == CW'((1 << AVG_LOG2) - 1);
    sum     = acc_q + AW'(adc_data_i);
    rounded = (AW+1)'(sum) + (AW+1)'(RND);
    load    = done && (!valid_q || avg_ready_i);
    state_d = !enable_i             ? IDLE :
              state_q == IDLE       ? RUN  :
              take                  ? RUN  :
              state_q == RUN && tick ? BUSY : state_q;
    // The schedule free-runs from entry into RUN; a late conversion never shifts it.
    timer_d = state_q == IDLE || timer_q == TW'(PERIOD - 1) ? '0 : timer_q + 1'b1;
    acc_d   = !enable_i || done ? '0 : take ? sum : acc_q;
    cnt_d   = !enable_i || done ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    data_d  = load ? 12'(rounded >> AVG_LOG2) : data_q;
    valid_d = load || (valid_q && !avg_ready_i);
    late_d  = (state_q == BUSY && tick) || (late_q && !clear_i);
    ovr_d   = (done && !load) || (ovr_q && !clear_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      late_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      late_q  <= late_d;
      ovr_q   <= ovr_d;
    end
  end

  assign request_o   = state_q == RUN && tick;
  assign avg_data_o  = data_q;
  assign avg_valid_o = valid_q;
  assign late_o      = late_q;
  assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_ad7476a_sample_averager.sv
// tb_ad7476a_sample_averager: directed tests against a sample-set level model of the averager
`timescale 1ns/1ps
module tb_ad7476a_sample_averager;
  localparam int P = 100;
  localparam int N = 4;

  logic clk = 0, rst_n = 0, enable = 0, clear = 0, adc_valid = 0, ready = 0;
  logic [11:0] adc_data = 0;
  logic request, avg_valid, late, overrun;
  logic [11:0] avg_data;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int delay = 30, cd = -1, nsent = 0;
  bit hold_v = 0;
  int sq[$];
  int reqt[$];
  int words[$];
  int vcyc = 0;

  bit m_on, m_pend, m_full, m_late, m_ovr;
  int m_start, m_data;
  int q[$];

  always #5 clk = ~clk;

  ad7476a_sample_averager #(.CLK_FREQ_HZ(100000000), .SAMPLE_RATE_HZ(1000000), .AVG_LOG2(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .clear_i(clear),
    .request_o(request), .adc_data_i(adc_data), .adc_valid_i(adc_valid),
    .avg_data_o(avg_data), .avg_valid_o(avg_valid), .avg_ready_i(ready),
    .late_o(late), .overrun_o(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_full = 0; m_late = 0; m_ovr = 0; m_data = 0; m_start = 0;
    q.delete();
  endtask

  // One clock of the model: ticks fall every P cycles after the run started, a set of N
  // collected samples yields round-half-up of their mean.
  task automatic model_step();
    bit tk, slate, sovr, done;
    int res, sum;
    tk = m_on && ((cyc - m_start) % P == 0);
    slate = tk && m_pend;
    sovr = 0; done = 0; res = 0;
    if (!enable) begin
      m_on = 0; m_pend = 0; q.delete();
    end else if (!m_on) begin
      m_on = 1; m_start = cyc + 1; m_pend = 0;
    end else if (m_pend) begin
      if (adc_valid) begin
        q.push_back(int'(adc_data));
        m_pend = 0;
        if (q.size() == N) begin
          sum = 0;
          foreach (q[i]) sum += q[i];
          res = (sum + N / 2) / N;
          done = 1;
          q.delete();
        end
      end
    end else if (tk) m_pend = 1;
    if (done) begin
      if (!m_full || ready) begin m_full = 1; m_data = res; end
      else sovr = 1;
    end else if (m_full && ready) m_full = 0;
    if (clear) begin m_late = 0; m_ovr = 0; end
    if (slate) m_late = 1;
    if (sovr) m_ovr = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge rst_n);
      model_reset();
    end
  end

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    adc_valid = hold_v;
    if (cd > 0) cd--;
    if (cd == 0) begin
      adc_valid = 1;
      adc_data = sq.size() > 0 ? 12'(sq.pop_front()) : 12'd7;
      nsent++;
      cd = -1;
    end
    if (request) cd = delay;
  end

  initial forever begin
    bit er;
    @(negedge clk);
    er = m_on && !m_pend && ((cyc - m_start) % P == 0);
    chk("request_o", int'(request), int'(er));
    chk("avg_valid_o", int'(avg_valid), int'(m_full));
    chk("avg_data_o", int'(avg_data), m_data);
    chk("late_o", int'(late), int'(m_late));
    chk("overrun_o", int'(overrun), int'(m_ovr));
    if (request) reqt.push_back(cyc);
    if (avg_valid) vcyc++;
    if (avg_valid && ready) words.push_back(int'(avg_data));
  end

  initial begin
    int e0, nw, ns;
    cycles(3);
    chk("rst_request", int'(request), 0);
    chk("rst_valid", int'(avg_valid), 0);
    chk("rst_data", int'(avg_data), 0);
    chk("rst_flags", int'({late, overrun}), 0);
    rst_n = 1;
    cycles(2);

    sq = {100, 101, 102, 103, 4095, 4095, 4095, 4095};
    ready = 1; delay = 30;
    enable = 1; e0 = cyc;
    for (int i = 0; i < 600 && reqt.size() < 4; i++) cycles(1);
    chk("t1_nreq", int'(reqt.size() >= 4), 1);
    if (reqt.size() >= 4) begin
      chk("t1_first", reqt[0], e0 + 1);
      chk("t1_period", reqt[1] - reqt[0], 100);
      chk("t1_period3", reqt[3] - reqt[2], 100);
    end
    for (int i = 0; i < 300 && words.size() < 1; i++) cycles(1);
    cycles(1);
    chk("t2_nword", int'(words.size() >= 1), 1);
    if (words.size() >= 1) chk("t2_mean", words[0], 102);
    chk("t2_vcycles", vcyc, 1);
    for (int i = 0; i < 600 && words.size() < 2; i++) cycles(1);
    chk("t2_nword2", int'(words.size() >= 2), 1);
    if (words.size() >= 2) chk("t2_max", words[1], 4095);

    enable = 0;
    cycles(40);
    sq.delete(); delay = 150;
    clear = 1; cycles(1); clear = 0;
    chk("t3_late_clr", int'(late), 0);
    reqt.delete();
    enable = 1;
    for (int i = 0; i < 500 && reqt.size() < 2; i++) cycles(1);
    cycles(1);
    chk("t3_late", int'(late), 1);
    chk("t3_nreq", int'(reqt.size() >= 2), 1);
    if (reqt.size() >= 2) chk("t3_gap", reqt[1] - reqt[0], 200);

    enable = 0;
    cycles(200);
    sq = {10, 20, 30, 40, 50, 50, 50, 51};
    delay = 30; ready = 0;
    clear = 1; cycles(1); clear = 0;
    enable = 1;
    for (int i = 0; i < 1200 && !overrun; i++) cycles(1);
    cycles(1);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_hold", int'(avg_data), 25);
    chk("t4_valid", int'(avg_valid), 1);
    enable = 0;
    cycles(5);
    chk("t4_kept", int'(avg_data), 25);
    clear = 1; cycles(1); clear = 0;
    chk("t4_clear", int'(overrun), 0);
    nw = words.size();
    ready = 1;
    cycles(2);
    chk("t4_accept", int'(words.size()), nw + 1);
    if (words.size() > nw) chk("t4_word", words[nw], 25);
    chk("t4_drop", int'(avg_valid), 0);

    cycles(40);
    sq = {1000, 1000, 8, 9, 10, 11};
    nw = words.size(); ns = nsent;
    enable = 1;
    for (int i = 0; i < 400 && nsent < ns + 2; i++) cycles(1);
    cycles(1);
    enable = 0;
    cycles(60);
    enable = 1;
    for (int i = 0; i < 700 && words.size() <= nw; i++) cycles(1);
    chk("t5_nword", int'(words.size() > nw), 1);
    if (words.size() > nw) chk("t5_fresh", words[nw], 10);

    reqt.delete();
    for (int i = 0; i < 200 && reqt.size() < 1; i++) cycles(1);
    cycles(10);
    hold_v = 1;
    #1 rst_n = 0;
    #1;
    chk("t6_request", int'(request), 0);
    chk("t6_valid", int'(avg_valid), 0);
    chk("t6_data", int'(avg_data), 0);
    chk("t6_late", int'(late), 0);
    chk("t6_overrun", int'(overrun), 0);
    enable = 0;
    cycles(3);
    rst_n = 1;
    reqt.delete();
    cycles(120);
    chk("t6_noreq", int'(reqt.size()), 0);
    hold_v = 0;
    enable = 1; e0 = cyc;
    for (int i = 0; i < 10 && reqt.size() < 1; i++) cycles(1);
    chk("t6_nreq", int'(reqt.size() >= 1), 1);
    if (reqt.size() >= 1) chk("t6_first", reqt[0], e0 + 1);
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
